// File: rtl/sram_pkg.sv
// sram_pkg: state encoding and timing defaults shared by the SRAM controller
package sram_pkg;
  typedef enum logic [2:0] {IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD} sram_state_e;
  localparam int RD_WAIT_DEF = 1;
  localparam int WR_WAIT_DEF = 1;
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: host-side request/response bundle of the SRAM controller
interface sram_ctrl_if;
  logic        s_req;
  logic        s_wr_req;
  logic        s_rd_req;
  logic [15:0] s_addr;
  logic [15:0] s_wdata;
  logic [15:0] s_rdata;
  logic        s_valid;
  logic        busy;
  logic        overrun;
  logic        wr_err;
  modport master (output s_req, s_wr_req, s_rd_req, s_addr, s_wdata,
                  input s_rdata, s_valid, busy, overrun, wr_err);
  modport slave (input s_req, s_wr_req, s_rd_req, s_addr, s_wdata,
                 output s_rdata, s_valid, busy, overrun, wr_err);
endinterface

// File: rtl/sram_ctrl_cnt.sv
// sram_ctrl_cnt: loadable down-counter with zero flag timing the wait states
module sram_ctrl_cnt (
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  // load while outside a timed state, otherwise count down and park at zero
  always_ff @(posedge s_clk)
    if (s_rst) cnt <= 4'd0;
    else cnt <= load ? load_val : (zero ? cnt : cnt - 4'd1);
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: async SRAM read/write sequencer with one pending slot; SRAM_WR_VERIFY_EN adds a write read-back check
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic        s_clk,
  input  logic        s_rst,
  sram_ctrl_if.slave  host,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);
`ifdef SRAM_WR_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  sram_state_e state;
  logic        pend_v, pend_wr, vfy, cnt_zero;
  logic [15:0] pend_addr, pend_wdata;
  logic        acc, both, fin, drain, start, take, drop, st_wr;
  logic [15:0] st_addr, st_wdata;
  sram_ctrl_cnt u_cnt (
    .s_clk    (s_clk),
    .s_rst    (s_rst),
    .load     (!(state == RD_ACC || state == WR_PULSE)),
    .load_val (state == WR_SETUP ? 4'(WR_WAIT) : 4'(RD_WAIT)),
    .zero     (cnt_zero)
  );
  assign acc      = host.s_req && (host.s_wr_req || host.s_rd_req);
  assign both     = host.s_req && host.s_wr_req && host.s_rd_req;
  assign fin      = state == RD_DONE || (state == WR_HOLD && !VFY);
  assign drain    = fin && pend_v;
  assign start    = (state == IDLE && acc) || drain;
  assign take     = acc && state != IDLE && (!pend_v || drain);
  assign drop     = both || (acc && state != IDLE && pend_v && !drain);
  assign st_wr    = drain ? pend_wr : host.s_wr_req;
  assign st_addr  = drain ? pend_addr : host.s_addr;
  assign st_wdata = drain ? pend_wdata : host.s_wdata;
  assign host.busy = state != IDLE || pend_v;
  // access sequencer: state, pending slot and all registered SRAM/host outputs
  always_ff @(posedge s_clk)
    if (s_rst) begin
      state        <= IDLE;
      pend_v       <= 1'b0;
      pend_wr      <= 1'b0;
      pend_addr    <= 16'd0;
      pend_wdata   <= 16'd0;
      vfy          <= 1'b0;
      host.s_valid <= 1'b0;
      host.s_rdata <= 16'd0;
      host.overrun <= 1'b0;
      sram_addr    <= 16'd0;
      sram_dq_o    <= 16'd0;
      sram_dq_oe   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      host.s_valid <= 1'b0;
      if (drop) host.overrun <= 1'b1;
      if (take) begin
        pend_v     <= 1'b1;
        pend_wr    <= host.s_wr_req;
        pend_addr  <= host.s_addr;
        pend_wdata <= host.s_wdata;
      end else if (drain) pend_v <= 1'b0;
      case (state)
        RD_ACC: if (cnt_zero) begin
          state     <= RD_DONE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          if (!vfy) begin
            host.s_rdata <= sram_dq_i;
            host.s_valid <= 1'b1;
          end
        end
        RD_DONE: begin
          state <= IDLE;
          vfy   <= 1'b0;
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          sram_we_n <= 1'b0;
        end
        WR_PULSE: if (cnt_zero) begin
          state     <= WR_HOLD;
          sram_we_n <= 1'b1;
        end
        WR_HOLD: begin
          state      <= VFY ? RD_ACC : IDLE;
          vfy        <= VFY;
          sram_ce_n  <= !VFY;
          sram_oe_n  <= !VFY;
          sram_dq_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (start) begin
        state      <= st_wr ? WR_SETUP : RD_ACC;
        sram_addr  <= st_addr;
        sram_ce_n  <= 1'b0;
        sram_oe_n  <= st_wr;
        sram_we_n  <= 1'b1;
        sram_dq_oe <= st_wr;
        if (st_wr) sram_dq_o <= st_wdata;
      end
    end
`ifdef SRAM_WR_VERIFY_EN
  logic wr_err_q;
  // sticky flag when the read-back after a write differs from the driven data
  always_ff @(posedge s_clk)
    if (s_rst) wr_err_q <= 1'b0;
    else if (state == RD_ACC && cnt_zero && vfy && sram_dq_i != sram_dq_o) wr_err_q <= 1'b1;
  assign host.wr_err = wr_err_q;
`else
  assign host.wr_err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed scoreboard bench for sram_ctrl with a behavioural SRAM model
module tb_sram_ctrl;
`ifdef SRAM_WR_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  logic        s_clk = 1'b0;
  logic        s_rst = 1'b1;
  logic [15:0] sram_addr, sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] mem [0:65535];
  logic        force_zero = 1'b0;
  logic [15:0] exp_q [$];
  int          tests = 0, fails = 0, cyc = 0, valid_cnt = 0, we_low = 0, oe_cnt = 0;
  bit          contention = 1'b0;
  sram_ctrl_if b ();
  sram_ctrl #(.RD_WAIT(1), .WR_WAIT(2)) dut (
    .s_clk      (s_clk),
    .s_rst      (s_rst),
    .host       (b.slave),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );
  always #5 s_clk = ~s_clk;
  // SRAM model: stores while selected with we_n low, returns data while oe_n low
  always @(posedge s_clk) begin
    cyc++;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? (force_zero ? 16'h0000 : mem[sram_addr]) : 16'hDEAD;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  // monitor: pin activity counters and scoreboard pop on every s_valid
  always @(negedge s_clk) begin
    if (!sram_we_n) we_low++;
    if (sram_dq_oe) oe_cnt++;
    if (!sram_oe_n && sram_dq_oe) contention = 1'b1;
    if (b.s_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got s_valid with rdata %h, required no s_valid", b.s_rdata);
      end else chk("rdata", b.s_rdata, exp_q.pop_front());
    end
  end
  task automatic pulse(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
    @(posedge s_clk); #1;
    b.s_wr_req = wr;
    b.s_rd_req = rd;
    b.s_addr   = a;
    b.s_wdata  = d;
    @(posedge s_clk); #1;
    b.s_wr_req = 1'b0;
    b.s_rd_req = 1'b0;
  endtask
  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge s_clk);
      ok = !b.busy;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: busy still 1 after 60 cycles, required 0", nm);
    end
  endtask
  task automatic do_reset();
    @(posedge s_clk); #1;
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    s_rst = 1'b0;
  endtask
  initial begin
    int pc, vc, gap;
    b.s_req = 1'b0;
    b.s_wr_req = 1'b0;
    b.s_rd_req = 1'b0;
    b.s_addr = 16'h0;
    b.s_wdata = 16'h0;
    repeat (3) @(posedge s_clk);
    #1 s_rst = 1'b0;
    @(negedge s_clk);
    chk("rst_valid", 16'(b.s_valid), 16'h0);
    chk("rst_busy", 16'(b.busy), 16'h0);
    chk("rst_overrun", 16'(b.overrun), 16'h0);
    chk("rst_rdata", b.s_rdata, 16'h0);
    chk("rst_addr", sram_addr, 16'h0);
    chk("rst_dq_o", sram_dq_o, 16'h0);
    chk("rst_dq_oe", 16'(sram_dq_oe), 16'h0);
    chk("rst_strobes", 16'({sram_ce_n, sram_oe_n, sram_we_n}), 16'h7);
    chk("rst_wr_err", 16'(b.wr_err), 16'h0);
    b.s_req = 1'b1;
    we_low = 0; oe_cnt = 0; valid_cnt = 0;
    pulse(1'b1, 1'b0, 16'h0042, 16'hA5A5);
    wait_idle("wr");
    chk("wr_we_low_cycles", 16'(we_low), 16'd3);
    chk("wr_dq_oe_cycles", 16'(oe_cnt), 16'd5);
    chk("wr_mem", mem[16'h0042], 16'hA5A5);
    chk("wr_no_valid", 16'(valid_cnt), 16'd0);
    chk("idle_addr_hold", sram_addr, 16'h0042);
    chk("idle_strobes", 16'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 16'hE);
    pulse(1'b1, 1'b0, 16'h1234, 16'hBEEF);
    wait_idle("wr_beef");
    exp_q.push_back(16'hBEEF);
    pulse(1'b0, 1'b1, 16'h1234, 16'h0);
    @(negedge s_clk);
    chk("rd_c1_oe_n", 16'(sram_oe_n), 16'h0);
    chk("rd_c1_addr", sram_addr, 16'h1234);
    chk("rd_c1_dq_oe", 16'(sram_dq_oe), 16'h0);
    @(negedge s_clk);
    chk("rd_c2_oe_n", 16'(sram_oe_n), 16'h0);
    chk("rd_c2_valid", 16'(b.s_valid), 16'h0);
    @(negedge s_clk);
    chk("rd_c3_valid", 16'(b.s_valid), 16'h1);
    chk("rd_c3_oe_n", 16'(sram_oe_n), 16'h1);
    @(negedge s_clk);
    chk("rd_c4_valid", 16'(b.s_valid), 16'h0);
    chk("rd_hold", b.s_rdata, 16'hBEEF);
    chk("rd_overrun", 16'(b.overrun), 16'h0);
    valid_cnt = 0;
    exp_q.push_back(16'hBEEF);
    @(posedge s_clk); #1;
    b.s_wr_req = 1'b1; b.s_addr = 16'h0100; b.s_wdata = 16'h1111;
    pc = cyc;
    @(posedge s_clk); #1;
    b.s_wr_req = 1'b0; b.s_rd_req = 1'b1; b.s_addr = 16'h1234;
    @(posedge s_clk); #1;
    b.s_addr = 16'h0042;
    @(posedge s_clk); #1;
    b.s_rd_req = 1'b0;
    vc = -1; gap = 0;
    for (int i = 0; i < 40 && vc < 0; i++) begin
      @(negedge s_clk);
      if (!b.busy) gap++;
      if (b.s_valid) vc = cyc;
    end
    chk("q_latency", 16'(vc - pc), 16'(VFY ? 11 : 8));
    chk("q_busy_gap", 16'(gap), 16'd0);
    wait_idle("q");
    chk("q_overrun", 16'(b.overrun), 16'h1);
    chk("q_valid_cnt", 16'(valid_cnt), 16'd1);
    chk("q_mem", mem[16'h0100], 16'h1111);
    do_reset();
    @(negedge s_clk);
    chk("rst_clears_overrun", 16'(b.overrun), 16'h0);
    valid_cnt = 0;
    pulse(1'b1, 1'b1, 16'h0200, 16'h2222);
    wait_idle("sim");
    chk("sim_mem", mem[16'h0200], 16'h2222);
    chk("sim_overrun", 16'(b.overrun), 16'h1);
    chk("sim_no_valid", 16'(valid_cnt), 16'd0);
    b.s_req = 1'b0;
    pulse(1'b0, 1'b1, 16'h1234, 16'h0);
    @(negedge s_clk);
    chk("noreq_busy", 16'(b.busy), 16'h0);
    repeat (4) @(negedge s_clk);
    chk("noreq_no_valid", 16'(valid_cnt), 16'd0);
    b.s_req = 1'b1;
    pulse(1'b1, 1'b0, 16'h0300, 16'h3333);
    @(posedge s_clk); #1;
    s_rst = 1'b1;
    @(negedge s_clk);
    chk("rstw_we_n_before", 16'(sram_we_n), 16'h0);
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    @(negedge s_clk);
    chk("rstw_we_n", 16'(sram_we_n), 16'h1);
    chk("rstw_dq_oe", 16'(sram_dq_oe), 16'h0);
    chk("rstw_busy", 16'(b.busy), 16'h0);
    chk("rstw_overrun", 16'(b.overrun), 16'h0);
    valid_cnt = 0;
    exp_q.push_back(16'hBEEF);
    pulse(1'b0, 1'b1, 16'h1234, 16'h0);
    wait_idle("rstw_rd");
    chk("rstw_rd_valid", 16'(valid_cnt), 16'd1);
    force_zero = 1'b1;
    valid_cnt = 0;
    pulse(1'b1, 1'b0, 16'h0400, 16'h00FF);
    wait_idle("vfy");
    chk("vfy_wr_err", 16'(b.wr_err), 16'(VFY));
    chk("vfy_no_valid", 16'(valid_cnt), 16'd0);
    chk("vfy_mem", mem[16'h0400], 16'h00FF);
    force_zero = 1'b0;
    chk("no_contention", 16'(contention), 16'h0);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 1: extra read-access cycles (0..15).
REQ-002 SHALL have parameter WR_WAIT, default 1: extra write-strobe cycles (0..15).
REQ-003 SHALL have port s_clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port s_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_req, input, 1: request window; wr/rd pulses are ignored while low.
REQ-006 SHALL have ports s_wr_req and s_rd_req, input, 1 each: single-cycle access pulses.
REQ-007 SHALL have ports s_addr and s_wdata, input, 16 each: word address and write data, sampled with the pulse.
REQ-008 SHALL have port s_rdata, output, 16: read data, held until the next read completes.
REQ-009 SHALL have port s_valid, output, 1: single-cycle read-complete pulse.
REQ-010 SHALL have port busy, output, 1: high while not IDLE or the pending slot is full.
REQ-011 SHALL have port overrun, output, 1: sticky; set when a pulse is dropped.
REQ-012 SHALL have ports sram_addr (output, 16), sram_dq_o (output, 16), sram_dq_oe (output, 1), sram_dq_i (input, 16), and sram_ce_n, sram_oe_n, sram_we_n (output, 1 each).

Function
REQ-013 SHALL implement states IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-014 SHALL accept an access only on a pulse cycle with s_req=1, latching addr, wdata and direction.
REQ-015 SHALL give write priority when s_wr_req and s_rd_req are both high; the read is dropped and overrun is set.
REQ-016 Read: a pulse at cycle k SHALL give RD_ACC for cycles k+1..k+1+RD_WAIT, with ce_n=0, oe_n=0, dq_oe=0 and sram_addr driven.
REQ-017 Read: sram_dq_i SHALL be captured at the end of the last RD_ACC cycle; in RD_DONE (cycle k+2+RD_WAIT) s_rdata SHALL be updated and s_valid SHALL be 1 for exactly one cycle.
REQ-018 Write: WR_SETUP SHALL last 1 cycle with ce_n=0, we_n=1, oe_n=1, dq_oe=1 and addr/data driven.
REQ-019 Write: WR_PULSE SHALL last WR_WAIT+1 cycles with we_n=0, followed by WR_HOLD for 1 cycle with we_n=1 and data still driven.
REQ-020 dq_oe SHALL be 1 only in WR_SETUP, WR_PULSE and WR_HOLD; oe_n and dq_oe SHALL never both be active.
REQ-021 In IDLE: ce_n=oe_n=we_n=1 and dq_oe=0; sram_addr holds its last value.
REQ-022 SHALL provide a one-entry pending slot that captures a pulse accepted while not IDLE.
REQ-023 A pulse arriving while the pending slot is full SHALL be dropped and overrun set.
REQ-024 On leaving RD_DONE or WR_HOLD with the slot full, SHALL go directly to the pending access's first state with no IDLE cycle, and clear the slot.
REQ-025 A pulse in the same cycle the slot drains SHALL be accepted into the slot.
REQ-026 s_req falling mid-access SHALL NOT abort the access or the pending entry.

Reset
REQ-027 s_rst SHALL force IDLE, clear the slot, and set s_valid=0, busy=0, overrun=0, s_rdata=0, sram_addr=0, dq_o=0, dq_oe=0, ce_n=oe_n=we_n=1.
REQ-028 Reset mid-write SHALL deassert we_n and dq_oe in the first cycle after reset is sampled.
REQ-029 overrun SHALL clear only on reset.

Configuration
REQ-030 With SRAM_WR_VERIFY_EN defined: after WR_HOLD, SHALL perform a RD_ACC-timed read of the same address; on mismatch with the written data, SHALL set sticky output wr_err; no s_valid or s_rdata update for the verify read; busy stays high throughout.
REQ-031 Without SRAM_WR_VERIFY_EN: no verify read; wr_err SHALL exist and be tied 0.

Structure
REQ-032 State encoding and the RD_WAIT/WR_WAIT defaults SHALL live in shared package sram_pkg.
REQ-033 Sub-module sram_ctrl_cnt (loadable down-counter with zero flag) SHALL time RD_ACC and WR_PULSE; all else flat.

Verification
REQ-034 Read: RD_WAIT=1, sram model returns 16'hBEEF at 16'h1234; rd pulse at cycle 0 -> oe_n low in cycles 1-2, s_valid=1 only in cycle 3, s_rdata=16'hBEEF.
REQ-035 Write: WR_WAIT=2, write 16'hA5A5 to 16'h0042 -> we_n low exactly 3 cycles, dq_oe high 5 cycles, model holds 16'hA5A5.
REQ-036 Queuing: write, read one cycle later, third pulse next cycle -> read follows write with no IDLE gap, third pulse dropped, overrun=1.
REQ-037 Simultaneous wr+rd pulse -> only the write executes, overrun=1, no s_valid.
REQ-038 Reset during WR_PULSE -> next cycle we_n=1, dq_oe=0, busy=0; a following read returns correct data.
REQ-039 With SRAM_WR_VERIFY_EN and the model forced to return 16'h0000 after a write of 16'h00FF -> wr_err=1, no s_valid.
